pipe_mips32: RTL and testbench
==============================

# pipe_mips32

Five-stage in-order pipelined processor (IF, ID, EX, MEM, WB) for a reduced MIPS32-style integer ISA. It is a self-contained core with an internal word-addressed unified instruction/data memory and a 32×32 register file. Benches preload both memory and registers through hierarchical references. The core runs until it retires a HLT instruction.

## Interface
- No parameters; memory depth fixed at 1024 words.
- clk1  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- halted  output  1  high once HLT has retired; reset value 0.
- Hierarchically accessible state (exact names):
  - Mem[0:1023] (32-bit)
  - Reg[0:31] (32-bit)
  - pc (32-bit)
  - HALTED
  - TAKEN_BRANCH

## Operation
- Instruction fields:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
  - imm [15:0], sign-extended to 32 bits.
- Register-register ops (rd ← rs op rt), opcodes:
  - ADD=0, SUB=1, AND=2, OR=3
  - SLT=4 (signed, result 1/0)
  - MUL=5 (low 32 bits)
- Register-immediate ops (rt ← rs op imm): ADDI=10, SUBI=11, SLTI=12.
- Loads/stores:
  - LW=8: rt ← Mem[rs+imm].
  - SW=9: Mem[rs+imm] ← rt.
- Branches, target = PC+1+imm (word addressing):
  - BNEZ=13: taken if rs≠0.
  - BEQZ=14: taken if rs=0.
- HLT=63. Any other opcode executes as a NOP.
- pc counts words; sequential fetch is pc+1.
- R0: reads return 0; writes to R0 are discarded.
- Reset clears pc, HALTED, TAKEN_BRANCH and all pipeline valid bits (every stage holds a bubble). Reset does not clear Reg or Mem.
- Data hazards:
  - Full forwarding of ALU results from EX/MEM and MEM/WB to both EX operands.
  - The register file is write-through: a WB write is visible to an ID read in the same cycle.
  - No load-use interlock: software places at least one instruction between an LW and its consumer. Otherwise the consumer receives the stale value.
- Branches:
  - Resolved in EX.
  - When taken, pc ← target, TAKEN_BRANCH pulses for one cycle, and the two younger instructions (in IF/ID and ID/EX) are squashed.
- HLT:
  - When HLT is decoded, fetch stops and pc freezes.
  - Instructions older than HLT complete normally; younger ones are squashed.
  - When HLT reaches WB, HALTED sets. After that no further Reg or Mem writes occur until reset.
- Arithmetic wraps modulo 2^32; no overflow exceptions.
- Memory addresses use bits [9:0] only; out-of-range addresses wrap.

## Timing
- Instruction k (no branches taken) is fetched at edge k+1 after reset release and writes back at edge k+5.
- Throughput is 1 instruction/cycle. A taken branch costs 2 bubbles.
- halted rises on the edge where HLT is in WB. A HLT at word 8 asserts halted after edge 13.
- Stores commit at the MEM edge. Loads read memory in MEM and write Reg in WB.
- Reset asserted mid-program:
  - On the next edge, all in-flight instructions are squashed, pc=0 and halted=0.
  - A Mem or Reg write scheduled on that same edge is suppressed.

## Configuration
- MUL_EN defined: opcode 5 performs 32×32 multiply, low 32 bits to rd.
- MUL_EN undefined: opcode 5 is a NOP (no register write); no multiplier is synthesized.

## Structure
- Shared package pipe_mips32_pkg holds:
  - opcode localparams
  - instruction-type enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  - register/memory depth constants
- One natural sub-module: pipe_mips32_alu, a combinational ALU taking opcode and two operands, returning the result.

## Test plan
- Preload Reg[k]=k, then run:
  - Mem0–8 = 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000
  - Required: R1=10, R2=20, R3=25, R4=30, R5=55, halted=1 by cycle 14.
- Back-to-back dependency ADDI R1,R0,7; ADD R2,R1,R1; ADD R3,R2,R1 -> R2=14, R3=21 (forwarding).
- With Mem[100]=85: LW R2,100(R0); NOP; ADDI R3,R2,45; SW R3,101(R0) -> Mem[101]=130.
- Loop: R1=5, R2=0, body ADDI R2,R2,3; SUBI R1,R1,1; BNEZ R1,-3 -> R2=15, R1=0. Instructions after the branch never write while the branch is taken.
- Assert rst mid-program after R1 is written -> pc=0, halted=0; the program restarts and R1 is rewritten with the same value.
- MUL R3,R1,R2 with R1=6, R2=7 -> R3=42 with MUL_EN; without MUL_EN, R3 keeps its prior value.

Source files
------------

// File: rtl/pipe_mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline-register layouts for pipe_mips32.
// Optional multiplier support is selected with the MUL_EN macro.
package pipe_mips32_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;
  localparam int REG_COUNT = 32;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_SLT  = 6'd4;
  localparam logic [5:0] OP_MUL  = 6'd5;
  localparam logic [5:0] OP_LW   = 6'd8;
  localparam logic [5:0] OP_SW   = 6'd9;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_SUBI = 6'd11;
  localparam logic [5:0] OP_SLTI = 6'd12;
  localparam logic [5:0] OP_BNEZ = 6'd13;
  localparam logic [5:0] OP_BEQZ = 6'd14;
  localparam logic [5:0] OP_HLT  = 6'd63;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, OTHER
  } instr_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    instr_type_e itype;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } idex_t;

  typedef struct packed {
    logic        valid;
    instr_type_e itype;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] alu;
    logic [31:0] b;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    instr_type_e itype;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] val;
  } memwb_t;

  function automatic instr_type_e decode_type(input logic [5:0] op);
    instr_type_e t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: t = RR_ALU;
`ifdef MUL_EN
      OP_MUL:                                t = RR_ALU;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:             t = RM_ALU;
      OP_LW:                                 t = LOAD;
      OP_SW:                                 t = STORE;
      OP_BNEZ, OP_BEQZ:                      t = BRANCH;
      OP_HLT:                                t = HALT;
      default:                               t = OTHER;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipe_mips32_if.sv
// Retirement trace of pipe_mips32: register writebacks and committed stores.
interface pipe_mips32_if;
  import pipe_mips32_pkg::*;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              st_valid;
  logic [MEM_AW-1:0] st_addr;
  logic [31:0]       st_data;

  modport master (output wb_valid, wb_rd, wb_data, st_valid, st_addr, st_data);
  modport slave  (input  wb_valid, wb_rd, wb_data, st_valid, st_addr, st_data);
endinterface

// File: rtl/pipe_mips32_alu.sv
// Combinational ALU; immediate forms and load/store address generation share the
// register-register datapath. MUL_EN enables the multiplier.
module pipe_mips32_alu
  import pipe_mips32_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = 32'd0;
    case (op_i)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: y_o = a_i + b_i;
      OP_SUB, OP_SUBI:               y_o = a_i - b_i;
      OP_AND:                        y_o = a_i & b_i;
      OP_OR:                         y_o = a_i | b_i;
      OP_SLT, OP_SLTI:               y_o = {31'd0, ($signed(a_i) < $signed(b_i))};
`ifdef MUL_EN
      OP_MUL:                        y_o = a_i * b_i;
`endif
      default:                       y_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-style core with unified word memory and 32x32 register file.
// MUL_EN selects the optional multiply instruction.
module pipe_mips32
  import pipe_mips32_pkg::*;
(
  input  logic                 clk1,
  input  logic                 rst,
  output logic                 halted,
  pipe_mips32_if.master        trc_o
);

  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] Reg [0:REG_COUNT-1];
  logic [31:0] pc;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic [31:0] pc_d;
  logic        halted_d, taken_branch_d;
  logic        halt_seen_q, halt_seen_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [4:0]  id_rs_s, id_rt_s, id_rd_s;
  logic [31:0] rd_a_s, rd_b_s, fwd_a_s, fwd_b_s, alu_b_s, alu_y_s, br_target_s;
  logic        wb_write_s, mem_we_s, br_taken_s, hlt_dec_s;

  assign id_rs_s = ifid_q.ir[25:21];
  assign id_rt_s = ifid_q.ir[20:16];
  assign id_rd_s = ifid_q.ir[15:11];

  assign wb_write_s = memwb_q.valid && memwb_q.we && !HALTED && !rst;
  assign mem_we_s   = exmem_q.valid && (exmem_q.itype == STORE) && !HALTED && !rst;

  // Register read; a writeback in the same cycle is passed straight through
  always_comb begin
    rd_a_s = 32'd0;
    rd_b_s = 32'd0;
    if (id_rs_s == 5'd0) rd_a_s = 32'd0;
    else if (wb_write_s && memwb_q.dest == id_rs_s) rd_a_s = memwb_q.val;
    else rd_a_s = Reg[id_rs_s];
    if (id_rt_s == 5'd0) rd_b_s = 32'd0;
    else if (wb_write_s && memwb_q.dest == id_rt_s) rd_b_s = memwb_q.val;
    else rd_b_s = Reg[id_rt_s];
  end

  // Loads in EX/MEM have no data yet, so only ALU results forward from there
  always_comb begin
    fwd_a_s = idex_q.a;
    fwd_b_s = idex_q.b;
    if (exmem_q.valid && exmem_q.we && exmem_q.itype != LOAD && exmem_q.dest == idex_q.rs)
      fwd_a_s = exmem_q.alu;
    else if (memwb_q.valid && memwb_q.we && memwb_q.dest == idex_q.rs)
      fwd_a_s = memwb_q.val;
    else
      fwd_a_s = idex_q.a;
    if (exmem_q.valid && exmem_q.we && exmem_q.itype != LOAD && exmem_q.dest == idex_q.rt)
      fwd_b_s = exmem_q.alu;
    else if (memwb_q.valid && memwb_q.we && memwb_q.dest == idex_q.rt)
      fwd_b_s = memwb_q.val;
    else
      fwd_b_s = idex_q.b;
  end

  assign alu_b_s     = (idex_q.itype == RR_ALU) ? fwd_b_s : idex_q.imm;
  assign br_target_s = idex_q.npc + idex_q.imm;
  assign br_taken_s  = idex_q.valid && (idex_q.itype == BRANCH) &&
                       ((idex_q.op == OP_BEQZ) == (fwd_a_s == 32'd0));
  assign hlt_dec_s   = ifid_q.valid && (decode_type(ifid_q.ir[31:26]) == HALT) && !br_taken_s;

  pipe_mips32_alu u_alu (
    .op_i (idex_q.op),
    .a_i  (fwd_a_s),
    .b_i  (alu_b_s),
    .y_o  (alu_y_s)
  );

  always_comb begin
    pc_d           = pc;
    ifid_d         = '0;
    halt_seen_d    = halt_seen_q | hlt_dec_s;
    halted_d       = HALTED | (memwb_q.valid && memwb_q.itype == HALT);
    taken_branch_d = br_taken_s;
    if (br_taken_s) begin
      pc_d = br_target_s;
    end else if (halt_seen_q || hlt_dec_s) begin
      pc_d = pc;
    end else begin
      ifid_d.valid = 1'b1;
      ifid_d.ir    = Mem[pc[MEM_AW-1:0]];
      ifid_d.npc   = pc + 32'd1;
      pc_d         = pc + 32'd1;
    end

    idex_d       = '0;
    idex_d.valid = ifid_q.valid && !br_taken_s;
    idex_d.itype = decode_type(ifid_q.ir[31:26]);
    idex_d.op    = ifid_q.ir[31:26];
    idex_d.rs    = id_rs_s;
    idex_d.rt    = id_rt_s;
    idex_d.dest  = (idex_d.itype == RR_ALU) ? id_rd_s : id_rt_s;
    idex_d.we    = idex_d.valid && (idex_d.dest != 5'd0) &&
                   (idex_d.itype == RR_ALU || idex_d.itype == RM_ALU || idex_d.itype == LOAD);
    idex_d.a     = rd_a_s;
    idex_d.b     = rd_b_s;
    idex_d.imm   = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
    idex_d.npc   = ifid_q.npc;

    exmem_d.valid = idex_q.valid;
    exmem_d.itype = idex_q.itype;
    exmem_d.dest  = idex_q.dest;
    exmem_d.we    = idex_q.we;
    exmem_d.alu   = alu_y_s;
    exmem_d.b     = fwd_b_s;

    memwb_d.valid = exmem_q.valid;
    memwb_d.itype = exmem_q.itype;
    memwb_d.dest  = exmem_q.dest;
    memwb_d.we    = exmem_q.we;
    memwb_d.val   = (exmem_q.itype == LOAD) ? Mem[exmem_q.alu[MEM_AW-1:0]] : exmem_q.alu;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pc           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      halt_seen_q  <= 1'b0;
      ifid_q       <= '0;
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
    end else begin
      pc           <= pc_d;
      HALTED       <= halted_d;
      TAKEN_BRANCH <= taken_branch_d;
      halt_seen_q  <= halt_seen_d;
      ifid_q       <= ifid_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
    end
  end

  // Architectural writes; both enables already exclude reset and the halted state
  always_ff @(posedge clk1) begin
    if (mem_we_s) Mem[exmem_q.alu[MEM_AW-1:0]] <= exmem_q.b;
    if (wb_write_s) Reg[memwb_q.dest] <= memwb_q.val;
  end

  assign halted         = HALTED;
  assign trc_o.wb_valid = wb_write_s;
  assign trc_o.wb_rd    = memwb_q.dest;
  assign trc_o.wb_data  = memwb_q.val;
  assign trc_o.st_valid = mem_we_s;
  assign trc_o.st_addr  = exmem_q.alu[MEM_AW-1:0];
  assign trc_o.st_data  = exmem_q.b;

endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: an instruction-level interpreter predicts the writeback/store
// stream, final state and halt edge; directed programs plus random straight-line programs.
module tb_pipe_mips32;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic halted;

  pipe_mips32_if trc ();

  pipe_mips32 dut (
    .clk1   (clk1),
    .rst    (rst),
    .halted (halted),
    .trc_o  (trc)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_reg [0:31];
  logic [4:0]  q_rd [$];
  logic [31:0] q_wd [$];
  logic [9:0]  q_sa [$];
  logic [31:0] q_sd [$];
  int exp_halt, exp_taken, n_taken_seen;
  bit chk_on = 1'b0;
  int last_edge;

  logic [31:0] p1 [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                            32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                            32'hfc000000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic void wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) begin
      m_reg[r] = v;
      q_rd.push_back(r);
      q_wd.push_back(v);
    end
  endfunction

  // Sequential ISA interpreter; each taken branch costs two extra fetch slots
  function automatic void model_run();
    logic [31:0] pc, ir, a, b, imm, ea;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    int n, tk;
    pc = 32'd0; n = 0; tk = 0; exp_halt = -1; exp_taken = 0;
    q_rd.delete(); q_wd.delete(); q_sa.delete(); q_sd.delete();
    for (int step = 0; step < 20000; step++) begin
      ir  = m_mem[pc[9:0]];
      op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      a   = (rs == 5'd0) ? 32'd0 : m_reg[rs];
      b   = (rt == 5'd0) ? 32'd0 : m_reg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      ea  = a + imm;
      if (op == 6'd63) begin
        exp_halt  = 1 + n + 2 * tk + 4;
        exp_taken = tk;
        break;
      end
      n++;
      case (op)
        6'd0:  wr(rd, a + b);
        6'd1:  wr(rd, a - b);
        6'd2:  wr(rd, a & b);
        6'd3:  wr(rd, a | b);
        6'd4:  wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
`ifdef MUL_EN
        6'd5:  wr(rd, a * b);
`endif
        6'd10: wr(rt, a + imm);
        6'd11: wr(rt, a - imm);
        6'd12: wr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
        6'd8:  wr(rt, m_mem[ea[9:0]]);
        6'd9:  begin m_mem[ea[9:0]] = b; q_sa.push_back(ea[9:0]); q_sd.push_back(b); end
        6'd13: if (a != 32'd0) begin pc = pc + imm; tk++; end
        6'd14: if (a == 32'd0) begin pc = pc + imm; tk++; end
        default: ;
      endcase
      pc = pc + 32'd1;
    end
  endfunction

  // Per-cycle comparison of the retirement trace against the predicted stream
  always @(negedge clk1) begin
    if (chk_on) begin
      if (trc.wb_valid) begin
        if (q_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_extra actual=R%0d:%0h required=none", trc.wb_rd, trc.wb_data);
        end else begin
          chk("wb_rd", 32'(trc.wb_rd), 32'(q_rd.pop_front()));
          chk("wb_data", trc.wb_data, q_wd.pop_front());
        end
      end
      if (trc.st_valid) begin
        if (q_sa.size() == 0) begin
          total++; bad++;
          $display("FAIL st_extra actual=%0h:%0h required=none", trc.st_addr, trc.st_data);
        end else begin
          chk("st_addr", 32'(trc.st_addr), 32'(q_sa.pop_front()));
          chk("st_data", trc.st_data, q_sd.pop_front());
        end
      end
      if (dut.TAKEN_BRANCH) n_taken_seen++;
    end
  end

  task automatic load_dut();
    rst = 1'b1;
    @(posedge clk1); @(posedge clk1); @(negedge clk1);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = m_mem[i];
    for (int i = 0; i < 32; i++) dut.Reg[i] = m_reg[i];
  endtask

  task automatic run_prog(input string nm, input int budget);
    int e;
    load_dut();
    model_run();
    n_taken_seen = 0;
    chk_on = 1'b1;
    rst = 1'b0;
    e = 0;
    while (e < budget && !halted) begin
      @(posedge clk1); @(negedge clk1);
      e++;
    end
    last_edge = e;
    chk({nm, "_halt_edge"}, 32'(e), 32'(exp_halt));
    repeat (4) @(negedge clk1);
    chk_on = 1'b0;
    chk({nm, "_leftover"}, 32'(q_rd.size() + q_sa.size()), 32'd0);
    chk({nm, "_taken"}, 32'(n_taken_seen), 32'(exp_taken));
    for (int i = 0; i < 32; i++) chk($sformatf("%s_R%0d", nm, i), dut.Reg[i], m_reg[i]);
    for (int i = 200; i < 216; i++) chk($sformatf("%s_M%0d", nm, i), dut.Mem[i], m_mem[i]);
  endtask

  task automatic clear_state();
    for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
  endtask

  task automatic setup_p1();
    clear_state();
    for (int i = 0; i < 9; i++) m_mem[i] = p1[i];
  endtask

  task automatic gen_random();
    int len, i, kind;
    logic [4:0] rs, rt, rd;
    for (int k = 0; k < 1024; k++) m_mem[k] = 32'd0;
    m_reg[0] = 32'd0;
    for (int k = 1; k < 32; k++) m_reg[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    for (int k = 200; k < 216; k++) m_mem[k] = $urandom;
    len = $urandom_range(12, 30);
    i = 0;
    while (i < len - 1) begin
      kind = $urandom_range(0, 9);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      case (kind)
        0, 1, 2, 3, 4: m_mem[i] = enc_r(6'($urandom_range(0, 5)), rs, rt, rd);
        5: m_mem[i] = enc_i(6'(10 + $urandom_range(0, 2)), rs, rt, 16'($urandom));
        6: if (i < len - 2) begin
             m_mem[i] = enc_i(6'd8, 5'd0, rt, 16'(200 + $urandom_range(0, 15)));
             i++;
             m_mem[i] = 32'h1c000000;
           end else begin
             m_mem[i] = 32'h1c000000;
           end
        7: m_mem[i] = enc_i(6'd9, 5'd0, rt, 16'(200 + $urandom_range(0, 15)));
        8: m_mem[i] = enc_i(6'(13 + $urandom_range(0, 1)), rs, 5'd0,
                            16'($urandom_range(0, len - 2 - i)));
        default: m_mem[i] = 32'h1c000000;
      endcase
      i++;
    end
    m_mem[len - 1] = 32'hfc000000;
  endtask

  initial begin
    // Reference program: five results and HLT at word 8
    setup_p1();
    run_prog("p1", 200);
    chk("p1_halt13", 32'(last_edge), 32'd13);
    chk("p1_R1", dut.Reg[1], 32'd10);
    chk("p1_R2", dut.Reg[2], 32'd20);
    chk("p1_R3", dut.Reg[3], 32'd25);
    chk("p1_R4", dut.Reg[4], 32'd30);
    chk("p1_R5", dut.Reg[5], 32'd55);
    chk("p1_halted", 32'(halted), 32'd1);

    // Back-to-back forwarding
    clear_state();
    m_mem[0] = enc_i(6'd10, 5'd0, 5'd1, 16'd7);
    m_mem[1] = enc_r(6'd0, 5'd1, 5'd1, 5'd2);
    m_mem[2] = enc_r(6'd0, 5'd2, 5'd1, 5'd3);
    m_mem[3] = 32'hfc000000;
    run_prog("fwd", 200);
    chk("fwd_R2", dut.Reg[2], 32'd14);
    chk("fwd_R3", dut.Reg[3], 32'd21);

    // Load, one filler, then dependent ALU op and store
    clear_state();
    m_mem[100] = 32'd85;
    m_mem[0] = enc_i(6'd8, 5'd0, 5'd2, 16'd100);
    m_mem[1] = 32'h1c000000;
    m_mem[2] = enc_i(6'd10, 5'd2, 5'd3, 16'd45);
    m_mem[3] = enc_i(6'd9, 5'd0, 5'd3, 16'd101);
    m_mem[4] = 32'hfc000000;
    run_prog("ldst", 200);
    chk("ldst_M101", dut.Mem[101], 32'd130);

    // Counted loop with an instruction in the branch shadow
    clear_state();
    m_reg[1] = 32'd5; m_reg[2] = 32'd0;
    m_mem[0] = enc_i(6'd10, 5'd2, 5'd2, 16'd3);
    m_mem[1] = enc_i(6'd11, 5'd1, 5'd1, 16'd1);
    m_mem[2] = enc_i(6'd13, 5'd1, 5'd0, 16'hfffd);
    m_mem[3] = enc_i(6'd10, 5'd0, 5'd6, 16'd77);
    m_mem[4] = 32'hfc000000;
    run_prog("loop", 400);
    chk("loop_R2", dut.Reg[2], 32'd15);
    chk("loop_R1", dut.Reg[1], 32'd0);
    chk("loop_halt29", 32'(last_edge), 32'd29);

    // Reset mid-program after R1 is written; the write due on the reset edge is dropped
    setup_p1();
    load_dut();
    rst = 1'b0;
    repeat (6) @(posedge clk1);
    @(negedge clk1);
    chk("mid_R1", dut.Reg[1], 32'd10);
    chk("mid_R3_pre", dut.Reg[3], 32'd3);
    rst = 1'b1;
    @(posedge clk1); @(negedge clk1);
    chk("mid_pc", dut.pc, 32'd0);
    chk("mid_halted", 32'(halted), 32'd0);
    chk("mid_R3_kept", dut.Reg[3], 32'd3);
    setup_p1();
    run_prog("restart", 200);
    chk("restart_R1", dut.Reg[1], 32'd10);

    // Multiply (optional feature)
    clear_state();
    m_reg[1] = 32'd6; m_reg[2] = 32'd7; m_reg[3] = 32'd3;
    m_mem[0] = enc_r(6'd5, 5'd1, 5'd2, 5'd3);
    m_mem[1] = 32'hfc000000;
    run_prog("mul", 200);
`ifdef MUL_EN
    chk("mul_R3", dut.Reg[3], 32'd42);
`else
    chk("mul_R3", dut.Reg[3], 32'd3);
`endif

    // Random programs
    for (int t = 0; t < 8; t++) begin
      gen_random();
      run_prog($sformatf("rnd%0d", t), 600);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
